// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - UART receiver line, frame configuration and result bundle
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
);
  logic                  RX_IN;
  logic [PRESC_W-1:0]    Prescale;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP,
    output P_DATA, data_valid, par_err, stp_err
  );

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP,
    input  P_DATA, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with majority vote, parity and stop checks
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic     CLK,
  input  logic     RST,
  uart_rx_if.slave bus
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0]      LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0]      BIT_ONE  = BW'(1);
  localparam logic [PRESC_W-1:0] ONE_P    = PRESC_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                r_state;
  logic                  r_meta;
  logic                  r_rx_s;
  logic [PRESC_W-1:0]    r_presc;
  logic [PRESC_W-1:0]    r_edge_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_s0;
  logic                  r_s1;
  logic                  r_bad;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_pdata;
  logic                  r_dv;
  logic                  r_pe;
  logic                  r_se;

  logic [PRESC_W-1:0]    w_half;
  logic                  w_last;
  logic                  w_decide;
  logic                  w_bit;
  logic                  w_par_exp;

  // The third vote is the live synchronized sample, so the decision lands on the edge after P/2+1.
  assign w_half    = {1'b0, r_presc[PRESC_W-1:1]};
  assign w_last    = (r_edge_cnt == (r_presc - ONE_P));
  assign w_decide  = (r_edge_cnt == (w_half + ONE_P));
  assign w_bit     = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);
  assign w_par_exp = (^r_shift) ^ r_par_typ;

  assign bus.P_DATA     = r_pdata;
  assign bus.data_valid = r_dv;
  assign bus.par_err    = r_pe;
  assign bus.stp_err    = r_se;

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_meta <= 1'b1;
      r_rx_s <= 1'b1;
    end else begin
      r_meta <= bus.RX_IN;
      r_rx_s <= r_meta;
    end
  end

  // Frame FSM: bit timing, vote sampling, data shifting and registered result pulses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_presc    <= '0;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_s0       <= 1'b0;
      r_s1       <= 1'b0;
      r_bad      <= 1'b0;
      r_shift    <= '0;
      r_pdata    <= '0;
      r_dv       <= 1'b0;
      r_pe       <= 1'b0;
      r_se       <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      r_pe <= 1'b0;
      r_se <= 1'b0;
      if (r_state != S_IDLE) begin
        if (r_edge_cnt == (w_half - ONE_P)) r_s0 <= r_rx_s;
        if (r_edge_cnt == w_half)           r_s1 <= r_rx_s;
        r_edge_cnt <= w_last ? '0 : (r_edge_cnt + ONE_P);
      end
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state    <= S_START;
            r_edge_cnt <= '0;
            r_presc    <= bus.Prescale;
            r_par_en   <= bus.PAR_EN;
            r_par_typ  <= bus.PAR_TYP;
            r_bad      <= 1'b0;
          end
        end
        S_START: begin
          if (w_decide && w_bit) begin
            // Start bit did not hold low through the vote: treat as line noise.
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
          end else if (w_last) begin
            r_state   <= S_DATA;
            r_bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (w_decide) r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
          if (w_last) begin
            r_bit_cnt <= r_bit_cnt + BIT_ONE;
            if (r_bit_cnt == LAST_BIT) r_state <= r_par_en ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (w_decide && (w_bit != w_par_exp)) begin
            r_pe  <= 1'b1;
            r_bad <= 1'b1;
          end
          if (w_last) r_state <= S_STOP;
        end
        S_STOP: begin
          if (w_decide) begin
            if (!w_bit) begin
              r_se <= 1'b1;
            end else if (!r_bad) begin
              r_pdata <= r_shift;
              r_dv    <= 1'b1;
            end
            // Leave mid stop bit so a start bit at nominal timing is not missed.
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed vector bench for uart_rx
module tb_uart_rx;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  uart_rx_if #(.DATA_WIDTH(8), .PRESC_W(6)) bus ();

  uart_rx #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    int         p;
    logic       pen;
    logic       ptyp;
    logic [7:0] d;
    logic       pbit;
    logic       stop;
    int         dv_cyc;
    int         pe_cyc;
    int         se_cyc;
    logic [7:0] exp_pd;
  } vec_t;

  vec_t       vecs[8];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         t0 = 0;
  int         dv_n = 0, pe_n = 0, se_n = 0, ovl_n = 0;
  int         dv_last = 0, pe_last = 0, se_last = 0;
  logic [7:0] dv_q[$];

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (bus.data_valid) begin
      dv_n++;
      dv_last = cyc;
      dv_q.push_back(bus.P_DATA);
    end
    if (bus.par_err) begin
      pe_n++;
      pe_last = cyc;
    end
    if (bus.stp_err) begin
      se_n++;
      se_last = cyc;
    end
    if (bus.data_valid && (bus.par_err || bus.stp_err)) ovl_n++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic idle(input int n);
    @(negedge CLK);
    bus.RX_IN = 1'b1;
    repeat (n - 1) @(negedge CLK);
  endtask

  task automatic configure(input int p, input logic pen, input logic ptyp);
    bus.Prescale = 6'(p);
    bus.PAR_EN   = pen;
    bus.PAR_TYP  = ptyp;
  endtask

  // Drives one frame; cycle 0 is the first rising edge that sees the start bit.
  task automatic send_frame(input int p, input logic [7:0] d, input logic pen,
                            input logic pbit, input logic stop, input bit flip, input int cut);
    logic [10:0] bits;
    int          nb;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    if (pen) begin
      bits[9]  = pbit;
      bits[10] = stop;
      nb       = 11;
    end else begin
      bits[9] = stop;
      nb      = 10;
    end
    for (int n = 0; n < nb; n++) begin
      for (int j = 0; j < p; j++) begin
        if (cut > 0 && (n * p + j) >= cut) return;
        @(negedge CLK);
        if (n == 0 && j == 0) t0 = cyc;
        bus.RX_IN = (flip && j == p / 2) ? ~bits[n] : bits[n];
      end
    end
  endtask

  initial begin
    int dv0, pe0, se0, q0;

    vecs[0] = '{8,  1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 88,  -1,  -1, 8'hA5};
    vecs[1] = '{16, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, -1,  156, -1, 8'hA5};
    vecs[2] = '{8,  1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, -1,  -1,  80, 8'hA5};
    vecs[3] = '{8,  1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 80,  -1,  -1, 8'h81};
    vecs[4] = '{16, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 156, -1,  -1, 8'hC3};
    vecs[5] = '{32, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 340, -1,  -1, 8'h01};
    vecs[6] = '{8,  1'b1, 1'b0, 8'h0F, 1'b1, 1'b0, -1,  80,  88, 8'h01};
    vecs[7] = '{32, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b1, 340, -1,  -1, 8'hFE};

    bus.RX_IN = 1'b1;
    configure(8, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    chk("reset P_DATA", int'(bus.P_DATA), 0);
    chk("reset data_valid", int'(bus.data_valid), 0);
    chk("reset par_err", int'(bus.par_err), 0);
    chk("reset stp_err", int'(bus.stp_err), 0);
    RST = 1'b1;
    repeat (8) @(negedge CLK);

    for (int v = 0; v < 8; v++) begin
      dv0 = dv_n; pe0 = pe_n; se0 = se_n;
      configure(vecs[v].p, vecs[v].pen, vecs[v].ptyp);
      send_frame(vecs[v].p, vecs[v].d, vecs[v].pen, vecs[v].pbit, vecs[v].stop, 1'b0, 0);
      idle(3 * vecs[v].p);
      chk($sformatf("vec%0d dv count", v), dv_n - dv0, (vecs[v].dv_cyc >= 0) ? 1 : 0);
      chk($sformatf("vec%0d par_err count", v), pe_n - pe0, (vecs[v].pe_cyc >= 0) ? 1 : 0);
      chk($sformatf("vec%0d stp_err count", v), se_n - se0, (vecs[v].se_cyc >= 0) ? 1 : 0);
      chk($sformatf("vec%0d P_DATA", v), int'(bus.P_DATA), int'(vecs[v].exp_pd));
      if (vecs[v].dv_cyc >= 0) chk($sformatf("vec%0d dv cycle", v), dv_last - t0 - 1, vecs[v].dv_cyc);
      if (vecs[v].pe_cyc >= 0) chk($sformatf("vec%0d par_err cycle", v), pe_last - t0 - 1, vecs[v].pe_cyc);
      if (vecs[v].se_cyc >= 0) chk($sformatf("vec%0d stp_err cycle", v), se_last - t0 - 1, vecs[v].se_cyc);
    end

    // Two-cycle low glitch must be rejected; a following frame lands on nominal timing.
    configure(8, 1'b0, 1'b0);
    dv0 = dv_n; pe0 = pe_n; se0 = se_n;
    send_frame(8, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    idle(24);
    chk("glitch pulses", (dv_n - dv0) + (pe_n - pe0) + (se_n - se0), 0);
    send_frame(8, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    idle(24);
    chk("post-glitch dv count", dv_n - dv0, 1);
    chk("post-glitch dv cycle", dv_last - t0 - 1, 80);
    chk("post-glitch P_DATA", int'(bus.P_DATA), 'h3C);

    // Back-to-back frames at P=32 with one corrupted sample per bit.
    configure(32, 1'b0, 1'b0);
    q0 = dv_q.size();
    pe0 = pe_n; se0 = se_n;
    send_frame(32, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    send_frame(32, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    send_frame(32, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    idle(64);
    chk("b2b dv count", dv_q.size() - q0, 3);
    chk("b2b error pulses", (pe_n - pe0) + (se_n - se0), 0);
    if (dv_q.size() - q0 == 3) begin
      chk("b2b frame0", int'(dv_q[q0]), 'h00);
      chk("b2b frame1", int'(dv_q[q0+1]), 'hFF);
      chk("b2b frame2", int'(dv_q[q0+2]), 'h55);
    end

    // Reset mid-DATA, then a clean frame.
    configure(8, 1'b0, 1'b0);
    dv0 = dv_n; pe0 = pe_n; se0 = se_n;
    send_frame(8, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 35);
    RST = 1'b0;
    bus.RX_IN = 1'b1;
    #1;
    chk("midreset P_DATA", int'(bus.P_DATA), 0);
    chk("midreset data_valid", int'(bus.data_valid), 0);
    chk("midreset errs", int'(bus.par_err) + int'(bus.stp_err), 0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    idle(16);
    chk("midreset no pulses", (dv_n - dv0) + (pe_n - pe0) + (se_n - se0), 0);
    send_frame(8, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    idle(24);
    chk("after reset dv count", dv_n - dv0, 1);
    chk("after reset dv cycle", dv_last - t0 - 1, 80);
    chk("after reset P_DATA", int'(bus.P_DATA), 'h12);

    // Break: line held low for 240 cycles gives repeated stop errors only.
    dv0 = dv_n; pe0 = pe_n; se0 = se_n;
    send_frame(8, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 160; i++) @(negedge CLK);
    idle(40);
    chk("break stp_err count", se_n - se0, 3);
    chk("break dv count", dv_n - dv0, 0);
    chk("break par_err count", pe_n - pe0, 0);
    chk("break P_DATA", int'(bus.P_DATA), 'h12);

    chk("dv overlapping error pulse", ovl_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
